// File: rtl/mmp_iddmm_pkg.sv
// Shared types and constants for the IDDMM operand sequencer and its result collector.
package mmp_iddmm_pkg;

    localparam int DEF_K = 128;
    localparam int DEF_N = 16;

    // One-hot core RAM write enables: bit0 = x, bit1 = y, bit2 = m.
    localparam logic [2:0] WEN_X = 3'b001;
    localparam logic [2:0] WEN_Y = 3'b010;
    localparam logic [2:0] WEN_M = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_M1,
        ST_LD_M,
        ST_LD_X,
        ST_LD_Y,
        ST_REQ,
        ST_RUN,
        ST_DONE
    } state_e;

    // Core RAM write enable for a word-loading phase; m1 and non-load states write nothing.
    function automatic logic [2:0] phase_wen(input state_e s);
        // NOTE: the default arm makes every input produce a value; the same habit in
        // always_comb (assign a default before any branch) is what keeps latches out.
        case (s)
            ST_LD_M: return WEN_M;
            ST_LD_X: return WEN_X;
            ST_LD_Y: return WEN_Y;
            default: return 3'b000;
        endcase
    endfunction

    // Phase that follows a completed N-word load phase.
    function automatic state_e phase_next(input state_e s);
        case (s)
            ST_LD_M: return ST_LD_X;
            ST_LD_X: return ST_LD_Y;
            default: return ST_REQ;
        endcase
    endfunction

endpackage

// File: rtl/mmp_iddmm_collect.sv
// Result collector: forwards up to N core result words one cycle after each grant,
// flags the Nth word, and reports whether exactly N words arrived.
module mmp_iddmm_collect
    import mmp_iddmm_pkg::*;
#(
    parameter int K      = DEF_K,
    parameter int N      = DEF_N,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         run_i,
    input  logic         grant_i,
    input  logic [K-1:0] res_i,
    output logic         r_valid_o,
    output logic [K-1:0] r_data_o,
    output logic         r_last_o,
    output logic         cnt_ok_o
);

    localparam int              CW        = ADDR_W + 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(N - 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(N);

    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          r_valid_q;
    logic          r_last_q;
    logic [K-1:0]  r_data_q;

    // Register each accepted grant; grants past the Nth are dropped and remembered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here sees the
            // pre-edge value of cnt_q regardless of statement order.
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (run_i && grant_i) begin
                if (cnt_q != CNT_FULL) begin
                    r_valid_q <= 1'b1;
                    r_data_q  <= res_i;
                    r_last_q  <= (cnt_q == CNT_LAST);
                    cnt_q     <= cnt_q + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;
    assign r_last_o  = r_last_q;
    assign cnt_ok_o  = (cnt_q == CNT_FULL) && !ovf_q;

endmodule

// File: rtl/mmp_iddmm_seq.sv
// Operand sequencer for the IDDMM Montgomery core: unpacks one word stream into the
// core's m1 register and x/y/m RAMs, issues the task, and frames the result words.
module mmp_iddmm_seq
    import mmp_iddmm_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int N       = DEF_N,
    parameter int ADDR_W  = $clog2(N),
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_m,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [K-1:0]      s_data,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic [K-1:0]      task_res,
    input  logic              task_end,
    output logic              r_valid,
    output logic [K-1:0]      r_data,
    output logic              r_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_valid
);

    localparam int              CW       = ADDR_W + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tmo_q;
    logic [K-1:0]      m1_q;
    logic [K-1:0]      wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [2:0]        wr_ena_q;
    logic              task_req_q;
    logic              done_q;
    logic              err_q;
    logic              m_valid_q;
    logic              hs;
    logic              cnt_ok;

    // Ready and busy are pure decodes of the state register, so they switch with it
    // and carry no input-to-output path.
    assign s_ready = (state_q == ST_LD_M1) || (state_q == ST_LD_M) ||
                     (state_q == ST_LD_X)  || (state_q == ST_LD_Y);
    assign busy    = (state_q != ST_IDLE);
    assign hs      = s_valid && s_ready;

    // Sequencer FSM with load path, write-port registers and RUN timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            m1_q       <= '0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_ena_q   <= '0;
            task_req_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            // Pulse outputs are high only in the cycle after the event that sets them.
            wr_ena_q   <= '0;
            task_req_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            // Every non-m1 handshake becomes a core write in the following cycle.
            if (hs && (state_q != ST_LD_M1)) begin
                wr_ena_q  <= phase_wen(state_q);
                wr_addr_q <= cnt_q[ADDR_W-1:0];
                wr_data_q <= s_data;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (load_m) begin
                            state_q <= ST_LD_M1;
                        end else if (m_valid_q) begin
                            state_q <= ST_LD_X;
                        end else begin
                            // x/y-only run with no modulus ever loaded.
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LD_M1: begin
                    if (hs) begin
                        m1_q    <= s_data;
                        cnt_q   <= '0;
                        state_q <= ST_LD_M;
                    end
                end
                ST_LD_M, ST_LD_X, ST_LD_Y: begin
                    if (hs) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= phase_next(state_q);
                            if (state_q == ST_LD_M) begin
                                m_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    task_req_q <= 1'b1;
                    tmo_q      <= '0;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    if (task_end) begin
                        state_q <= ST_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // The collector has already counted a grant coincident with task_end.
                    if (cnt_ok) begin
                        done_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mmp_iddmm_collect #(
        .K      (K),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_collect (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_REQ),
        .run_i     (state_q == ST_RUN),
        .grant_i   (task_grant),
        .res_i     (task_res),
        .r_valid_o (r_valid),
        .r_data_o  (r_data),
        .r_last_o  (r_last),
        .cnt_ok_o  (cnt_ok)
    );

    // The core re-latches m1 on every write, so m1 is presented continuously.
    assign wr_ena   = wr_ena_q;
    assign wr_addr  = wr_addr_q;
    assign wr_x     = wr_data_q;
    assign wr_y     = wr_data_q;
    assign wr_m     = wr_data_q;
    assign wr_m1    = m1_q;
    assign task_req = task_req_q;
    assign done     = done_q;
    assign err      = err_q;
    assign m_valid  = m_valid_q;

endmodule

// File: tb/tb_mmp_iddmm_seq.sv
// Bench for mmp_iddmm_seq: a per-cycle expectation table built from the stream order
// and core protocol rules, a compare process, and directed literal checks.
module tb_mmp_iddmm_seq;

    localparam int K       = 128;
    localparam int N       = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 4096;

    logic          clk, rst, start, load_m, s_valid, s_ready;
    logic [K-1:0]  s_data;
    logic [2:0]    wr_ena;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
    logic          task_req, task_grant, task_end;
    logic [K-1:0]  task_res;
    logic          r_valid, r_last, busy, done, err, m_valid;
    logic [K-1:0]  r_data;

    mmp_iddmm_seq #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .load_m(load_m),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m),
        .wr_m1(wr_m1), .task_req(task_req), .task_grant(task_grant),
        .task_res(task_res), .task_end(task_end), .r_valid(r_valid),
        .r_data(r_data), .r_last(r_last), .busy(busy), .done(done), .err(err),
        .m_valid(m_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected DUT outputs for one cycle; absent entries mean "everything idle".
    typedef struct packed {
        logic [2:0]    ena;
        logic [AW-1:0] addr;
        logic [K-1:0]  data;
        logic          req;
        logic          rv;
        logic [K-1:0]  rdata;
        logic          rlast;
        logic          done;
        logic          err;
    } exp_t;

    exp_t         exp_q [int];
    logic [K-1:0] exp_m1;
    logic [K-1:0] words [0:3*N];
    logic [K-1:0] core_x [0:N-1];
    logic [K-1:0] core_y [0:N-1];
    logic [K-1:0] core_m [0:N-1];
    int  cyc, n_checks, n_err;
    int  n_wm, n_wx, n_wy, n_rv, n_rlast, n_done, n_err_p;
    int  first_hs, last_hs, start_cyc, c0;
    bit  mon_en;
    logic [K-1:0] m1_saved;
    int  s_wm, s_wx, s_wy, s_rv, s_rlast, s_done, s_errp;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t get_exp(input int c);
        if (exp_q.exists(c)) return exp_q[c];
        return '0;
    endfunction

    task automatic exp_wr(input int c, input logic [2:0] en, input int a, input logic [K-1:0] d);
        exp_t e;
        e = get_exp(c);
        e.ena = en; e.addr = AW'(a); e.data = d;
        exp_q[c] = e;
    endtask

    task automatic exp_flag(input int c, input int which);
        exp_t e;
        e = get_exp(c);
        if (which == 0) e.req = 1'b1;
        if (which == 1) e.done = 1'b1;
        if (which == 2) e.err = 1'b1;
        exp_q[c] = e;
    endtask

    task automatic exp_rv(input int c, input logic [K-1:0] d, input logic last);
        exp_t e;
        e = get_exp(c);
        e.rv = 1'b1; e.rdata = d; e.rlast = last;
        exp_q[c] = e;
    endtask

    function automatic logic [K-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stream word idx handshaken in cycle c: derive its core write from the stream order.
    task automatic record(input bit lm, input int idx, input logic [K-1:0] w, input int c);
        int j, phase;
        logic [2:0] en;
        j = lm ? idx - 1 : idx;
        if (j < 0) return;
        phase = lm ? j / N : j / N + 1;
        en = (phase == 0) ? 3'b100 : (phase == 1) ? 3'b001 : 3'b010;
        exp_wr(c + 1, en, j % N, w);
        if (phase == 2 && (j % N) == N - 1) exp_flag(c + 2, 0);
    endtask

    // Present one word from a negedge until it is accepted (bounded).
    task automatic push(input logic [K-1:0] w, input bit lm, input int idx);
        bit hs;
        hs = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int k = 0; k < 20 && !hs; k++) begin
            if (s_ready) begin
                hs = 1'b1;
                if (idx == 0) first_hs = cyc;
                last_hs = cyc;
                record(lm, idx, w, cyc);
            end
            @(posedge clk);
            if (hs && lm && idx == 0) exp_m1 = w;
            @(negedge clk);
        end
        check("handshake", hs, 1);
    endtask

    task automatic do_load(input bit lm, input bit gaps, input int total);
        for (int i = 0; i < total; i++) words[i] = rnd_word();
        @(negedge clk);
        start = 1'b1; load_m = lm; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; load_m = 1'b0;
        for (int i = 0; i < total; i++) begin
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            push(words[i], lm, i);
        end
        s_valid = 1'b0;
    endtask

    // Core model: wait for task_req, emit n_gr grants, optionally end (with or after the last grant).
    task automatic run_core(input int n_gr, input bit do_end, input bit end_with_last, output int rc);
        bit seen;
        seen = 1'b0;
        rc = cyc;
        for (int k = 0; k < 16 && !seen; k++) begin
            if (task_req) begin
                seen = 1'b1;
                rc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("task_req_seen", seen, 1);
        for (int g = 0; g < n_gr; g++) begin
            @(negedge clk);
            task_grant = 1'b1;
            task_res   = rnd_word();
            if (g < N) exp_rv(cyc + 1, task_res, g == N - 1);
            if (do_end && end_with_last && g == n_gr - 1) begin
                task_end = 1'b1;
                exp_flag(cyc + 2, (n_gr == N) ? 1 : 2);
            end
        end
        @(negedge clk);
        task_grant = 1'b0;
        task_end   = 1'b0;
        if (do_end && !(end_with_last && n_gr > 0)) begin
            task_end = 1'b1;
            exp_flag(cyc + 2, (n_gr == N) ? 1 : 2);
            @(negedge clk);
            task_end = 1'b0;
        end
    endtask

    task automatic snap();
        s_wm = n_wm; s_wx = n_wx; s_wy = n_wy; s_rv = n_rv;
        s_rlast = n_rlast; s_done = n_done; s_errp = n_err_p;
    endtask

    // Cycle counter and the core's RAMs as the core itself would latch them.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_ena[0]) core_x[wr_addr] <= wr_x;
        if (wr_ena[1]) core_y[wr_addr] <= wr_y;
        if (wr_ena[2]) core_m[wr_addr] <= wr_m;
    end

    // Compare process: every cycle, all outputs against the expectation table.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (wr_ena == 3'b100) n_wm <= n_wm + 1;
        if (wr_ena == 3'b001) n_wx <= n_wx + 1;
        if (wr_ena == 3'b010) n_wy <= n_wy + 1;
        if (r_valid) n_rv <= n_rv + 1;
        if (r_last)  n_rlast <= n_rlast + 1;
        if (done)    n_done <= n_done + 1;
        if (err)     n_err_p <= n_err_p + 1;
        if (mon_en) begin
            e = get_exp(cyc);
            check("wr_ena", wr_ena, e.ena);
            if (e.ena != 3'b000) begin
                check("wr_addr", wr_addr, e.addr);
                check("wr_x", wr_x, e.data);
                check("wr_y", wr_y, e.data);
                check("wr_m", wr_m, e.data);
            end
            check("wr_m1", wr_m1, exp_m1);
            check("task_req", task_req, e.req);
            check("r_valid", r_valid, e.rv);
            if (e.rv) check("r_data", r_data, e.rdata);
            check("r_last", r_last, e.rlast);
            check("done", done, e.done);
            check("err", err, e.err);
        end
    end

    initial begin
        cyc = 0; n_checks = 0; n_err = 0; mon_en = 1'b0;
        n_wm = 0; n_wx = 0; n_wy = 0; n_rv = 0; n_rlast = 0; n_done = 0; n_err_p = 0;
        exp_m1 = '0;
        rst = 1'b1; start = 1'b0; load_m = 1'b0; s_valid = 1'b0; s_data = '0;
        task_grant = 1'b0; task_res = '0; task_end = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs_zero", |{wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
              r_valid, r_data, r_last, busy, done, err, m_valid, s_ready}, 0);
        check("rst_m_valid", m_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1 mon_en = 1'b1;

        // x/y-only start with no modulus loaded: one err pulse, never busy.
        @(negedge clk);
        start = 1'b1; load_m = 1'b0;
        exp_flag(cyc + 1, 2);
        @(negedge clk);
        start = 1'b0;
        check("noM_busy", busy, 0);
        check("noM_s_ready", s_ready, 0);
        @(negedge clk);
        check("noM_busy2", busy, 0);
        check("noM_m_valid", m_valid, 0);

        // Full 49-word load with m, 16 results, end the cycle after the last grant.
        snap();
        do_load(1'b1, 1'b0, 3 * N + 1);
        check("t1_m_valid", m_valid, 1);
        run_core(N, 1'b1, 1'b0, c0);
        check("t1_first_hs", first_hs, start_cyc + 1);
        check("t1_req_cycle", c0, first_hs + 50);
        repeat (4) @(negedge clk);
        check("t1_n_wm", n_wm - s_wm, 16);
        check("t1_n_wx", n_wx - s_wx, 16);
        check("t1_n_wy", n_wy - s_wy, 16);
        check("t1_n_rv", n_rv - s_rv, 16);
        check("t1_n_rlast", n_rlast - s_rlast, 1);
        check("t1_n_done", n_done - s_done, 1);
        check("t1_busy_after", busy, 0);
        for (int i = 0; i < N; i++) begin
            check("t1_core_m", core_m[i], words[1 + i]);
            check("t1_core_x", core_x[i], words[1 + N + i]);
            check("t1_core_y", core_y[i], words[1 + 2 * N + i]);
        end
        m1_saved = words[0];

        // x/y only, modulus kept; end coincides with the last grant.
        snap();
        do_load(1'b0, 1'b0, 2 * N);
        run_core(N, 1'b1, 1'b1, c0);
        check("t2_req_cycle", c0, first_hs + 2 * N + 1);
        repeat (4) @(negedge clk);
        check("t2_no_m_write", n_wm - s_wm, 0);
        check("t2_wr_m1", wr_m1, m1_saved);
        check("t2_n_done", n_done - s_done, 1);
        check("t2_n_rlast", n_rlast - s_rlast, 1);

        // s_valid toggling: one word every other cycle.
        snap();
        do_load(1'b0, 1'b1, 2 * N);
        run_core(N, 1'b1, 1'b0, c0);
        check("t3_last_hs", last_hs, first_hs + 62);
        check("t3_req_cycle", c0, first_hs + 64);
        repeat (4) @(negedge clk);
        check("t3_n_done", n_done - s_done, 1);

        // 15 grants then task_end: error, no done.
        snap();
        do_load(1'b0, 1'b0, 2 * N);
        run_core(N - 1, 1'b1, 1'b0, c0);
        repeat (4) @(negedge clk);
        check("t4_n_done", n_done - s_done, 0);
        check("t4_n_err", n_err_p - s_errp, 1);
        check("t4_n_rlast", n_rlast - s_rlast, 0);

        // 17 grants: the 17th is dropped and the run ends in error.
        snap();
        do_load(1'b0, 1'b0, 2 * N);
        run_core(N + 1, 1'b1, 1'b0, c0);
        repeat (4) @(negedge clk);
        check("t5_n_rv", n_rv - s_rv, 16);
        check("t5_n_done", n_done - s_done, 0);
        check("t5_n_err", n_err_p - s_errp, 1);

        // No task_end: timeout error after TIMEOUT RUN cycles.
        snap();
        do_load(1'b0, 1'b0, 2 * N);
        run_core(0, 1'b0, 1'b0, c0);
        exp_flag(c0 + TIMEOUT, 2);
        check("t6_busy_in_run", busy, 1);
        repeat (TIMEOUT + 4) @(negedge clk);
        check("t6_busy_after", busy, 0);
        check("t6_n_err", n_err_p - s_errp, 1);

        // Reset during LD_X, then an x/y-only start must be refused.
        do_load(1'b1, 1'b0, 1 + N + 5);
        check("t7_in_ld_x", s_ready, 1);
        #1 mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t7_rst_outputs_zero", |{wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
              r_valid, r_data, r_last, busy, done, err, m_valid, s_ready}, 0);
        check("t7_m_valid", m_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_m1 = '0;
        @(posedge clk); #1 mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1; load_m = 1'b0;
        exp_flag(cyc + 1, 2);
        @(negedge clk);
        start = 1'b0;
        check("t7_busy", busy, 0);
        @(negedge clk);
        check("t7_busy2", busy, 0);
        check("t7_m_valid_after", m_valid, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
